// File: rtl/jtcop_dump_trigger.sv
// rtl/jtcop_dump_trigger.sv - frame counter and dump-window trigger keyed to vs falling edges
//
// Purpose: counts vertical-sync falling edges since the last ROM download and
// opens a capture window at a programmed frame for a programmed frame count.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   vs              vertical sync; falling edge = frame boundary
//   downloading     ROM download in progress; holds frame_cnt at 0, rise aborts
//   arm             level request for a capture window
//   cfg_start       frame number that opens the window (latched on arm)
//   cfg_len         window length in frames, 0 = unlimited (latched on arm)
//   frame_cnt       frames seen since the last download ended
//   dump_on         capture window open
//   dump_start      one-cycle pulse on window open
//   dump_stop       one-cycle pulse on window close or abort
//   st              FSM state: 0 IDLE, 1 ARMED, 2 ACTIVE, 3 DONE
module jtcop_dump_trigger #(
  parameter int CW      = 32,
  parameter int LW      = 16,
  parameter int SYNC_VS = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          downloading,
  input  logic          arm,
  input  logic [CW-1:0] cfg_start,
  input  logic [LW-1:0] cfg_len,
  output logic [CW-1:0] frame_cnt,
  output logic          dump_on,
  output logic          dump_start,
  output logic          dump_stop,
  output logic [1:0]    st
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  logic vs_s;

  generate
    if (SYNC_VS != 0) begin : g_sync
      logic [1:0] vs_sync_q;
      logic [1:0] vs_sync_d;
      always_comb vs_sync_d = {vs_sync_q[0], vs};
      // Reset to 1 so leaving reset never looks like a falling edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vs_sync_q <= 2'b11;
        else        vs_sync_q <= vs_sync_d;
      end
      assign vs_s = vs_sync_q[1];
    end else begin : g_nosync
      assign vs_s = vs;
    end
  endgenerate

  logic          vs_l_q, vs_l_d;
  logic          dl_q, dl_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] start_l_q, start_l_d;
  logic [LW-1:0] len_l_q, len_l_d;
  logic [LW-1:0] len_cnt_q, len_cnt_d;
  logic          dump_on_q, dump_on_d;
  logic          dump_start_q, dump_start_d;
  logic          dump_stop_q, dump_stop_d;
  state_t        st_q, st_d;

  logic          fe;
  logic          dl_rise;
  logic [LW-1:0] len_cnt_inc;

  assign fe          = vs_l_q & ~vs_s;
  assign dl_rise     = downloading & ~dl_q;
  assign len_cnt_inc = len_cnt_q + LW'(1);

  always_comb begin
    vs_l_d       = vs_s;
    dl_d         = downloading;
    frame_cnt_d  = frame_cnt_q;
    start_l_d    = start_l_q;
    len_l_d      = len_l_q;
    len_cnt_d    = len_cnt_q;
    dump_on_d    = dump_on_q;
    dump_start_d = 1'b0;
    dump_stop_d  = 1'b0;
    st_d         = st_q;

    if (downloading)  frame_cnt_d = '0;
    else if (fe)      frame_cnt_d = frame_cnt_q + CW'(1);

    // Abort outranks every FSM transition, including a start match on this fe.
    if (dl_rise) begin
      st_d = IDLE;
      if (dump_on_q) begin
        dump_on_d   = 1'b0;
        dump_stop_d = 1'b1;
      end
    end else begin
      case (st_q)
        IDLE: begin
          // fe is ignored here, so an fe coincident with arm cannot start.
          if (arm && !downloading) begin
            start_l_d = cfg_start;
            len_l_d   = cfg_len;
            st_d      = ARMED;
          end
        end
        ARMED: begin
          if (!arm) begin
            st_d = IDLE;
          end else if (fe && frame_cnt_q == start_l_q) begin
            st_d         = ACTIVE;
            dump_on_d    = 1'b1;
            dump_start_d = 1'b1;
            len_cnt_d    = '0;
          end
        end
        ACTIVE: begin
          if (!arm) begin
            st_d        = IDLE;
            dump_on_d   = 1'b0;
            dump_stop_d = 1'b1;
          end else if (fe) begin
            if (len_l_q != '0 && len_cnt_inc == len_l_q) begin
              st_d        = DONE;
              dump_on_d   = 1'b0;
              dump_stop_d = 1'b1;
              len_cnt_d   = len_cnt_inc;
            end else if (len_cnt_q != '1) begin
              len_cnt_d = len_cnt_inc;
            end
          end
        end
        DONE: begin
          if (!arm) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_l_q       <= 1'b1;
      dl_q         <= 1'b0;
      frame_cnt_q  <= '0;
      start_l_q    <= '0;
      len_l_q      <= '0;
      len_cnt_q    <= '0;
      dump_on_q    <= 1'b0;
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
      st_q         <= IDLE;
    end else begin
      vs_l_q       <= vs_l_d;
      dl_q         <= dl_d;
      frame_cnt_q  <= frame_cnt_d;
      start_l_q    <= start_l_d;
      len_l_q      <= len_l_d;
      len_cnt_q    <= len_cnt_d;
      dump_on_q    <= dump_on_d;
      dump_start_q <= dump_start_d;
      dump_stop_q  <= dump_stop_d;
      st_q         <= st_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign dump_on    = dump_on_q;
  assign dump_start = dump_start_q;
  assign dump_stop  = dump_stop_q;
  assign st         = st_q;

endmodule

// File: tb/tb_jtcop_dump_trigger.sv
// tb/tb_jtcop_dump_trigger.sv - directed self-checking bench for jtcop_dump_trigger
module tb_jtcop_dump_trigger;

  localparam int CW = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vs;
  logic          downloading;
  logic          arm;
  logic [CW-1:0] cfg_start;
  logic [LW-1:0] cfg_len;
  logic [CW-1:0] frame_cnt;
  logic          dump_on;
  logic          dump_start;
  logic          dump_stop;
  logic [1:0]    st;

  int tests_run    = 0;
  int tests_failed = 0;
  int both_cnt     = 0;

  logic [CW-1:0] exp_cnt;
  logic          fe_start, fe_stop, fe_on;
  int            off_cnt;

  jtcop_dump_trigger #(.CW(CW), .LW(LW), .SYNC_VS(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vs          (vs),
    .downloading (downloading),
    .arm         (arm),
    .cfg_start   (cfg_start),
    .cfg_len     (cfg_len),
    .frame_cnt   (frame_cnt),
    .dump_on     (dump_on),
    .dump_start  (dump_start),
    .dump_stop   (dump_stop),
    .st          (st)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dump_start && dump_stop) both_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: vs low for a cycle (fe seen on the first edge), then high.
  task automatic frame();
    vs = 1'b0;
    tick();
    fe_start = dump_start;
    fe_stop  = dump_stop;
    fe_on    = dump_on;
    exp_cnt  = downloading ? '0 : exp_cnt + 4'd1;
    vs = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b1; downloading = 1'b0; arm = 1'b0;
    cfg_start = '0; cfg_len = '0; exp_cnt = '0;
    tick(); tick();
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_outputs", {dump_on, dump_start, dump_stop}, 0);
    check("rst_st", st, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) frame();
    check("five_fe_cnt", frame_cnt, 5);
    check("five_fe_dump_on", dump_on, 0);
    check("five_fe_st", st, 0);

    // Start 3, length 2, from frame 0.
    downloading = 1'b1; tick(); downloading = 1'b0; tick();
    exp_cnt = '0;
    check("dl_clear_cnt", frame_cnt, 0);
    cfg_start = 4'd3; cfg_len = 8'd2; arm = 1'b1;
    tick();
    check("armed_st", st, 1);
    cfg_start = 4'd9; cfg_len = 8'd7;
    for (int i = 0; i < 3; i++) frame();
    check("pre_start_on", dump_on, 0);
    frame();
    check("start_pulse", fe_start, 1);
    check("start_cnt", frame_cnt, 4);
    check("start_pulse_width", dump_start, 0);
    check("active_st", st, 2);
    frame();
    check("len_mid_on", fe_on, 1);
    check("len_mid_stop", fe_stop, 0);
    frame();
    check("len_end_stop", fe_stop, 1);
    check("len_end_on", fe_on, 0);
    check("len_end_cnt", frame_cnt, 6);
    check("done_st", st, 3);
    frame();
    check("done_hold_st", st, 3);
    arm = 1'b0;
    tick();
    check("done_to_idle", st, 0);

    // Unlimited window (exp_cnt = 7 here, start at 8).
    cfg_start = exp_cnt + 4'd1; cfg_len = 8'd0; arm = 1'b1;
    tick();
    frame(); frame();
    check("unl_start", fe_start, 1);
    off_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      frame();
      if (!fe_on || fe_stop || !dump_on) off_cnt++;
    end
    check("unl_100_on", off_cnt, 0);
    arm = 1'b0;
    tick();
    check("unl_drop_stop", dump_stop, 1);
    check("unl_drop_on", dump_on, 0);
    check("unl_drop_st", st, 0);

    // Abort by download during ACTIVE, coincident with an fe.
    cfg_start = exp_cnt; cfg_len = 8'd0; arm = 1'b1;
    tick();
    frame();
    check("abort_pre_on", fe_on, 1);
    vs = 1'b0; downloading = 1'b1;
    tick();
    check("abort_stop", dump_stop, 1);
    check("abort_on", dump_on, 0);
    check("abort_st", st, 0);
    check("abort_cnt", frame_cnt, 0);
    vs = 1'b1; tick();
    frame();
    check("dl_hold_cnt", frame_cnt, 0);
    check("dl_hold_st", st, 0);
    arm = 1'b0; downloading = 1'b0; tick();
    exp_cnt = '0;

    // Wrap: run to 14, then start=1 must wait for 15->0->1.
    for (int i = 0; i < 14; i++) frame();
    check("pre_wrap_cnt", frame_cnt, 14);
    cfg_start = 4'd1; arm = 1'b1; tick();
    frame(); frame();
    check("wrap_cnt", frame_cnt, 0);
    check("wrap_armed", st, 1);
    frame();
    check("wrap_no_start", fe_start, 0);
    frame();
    check("wrap_start", fe_start, 1);
    check("wrap_start_cnt", frame_cnt, 2);
    arm = 1'b0; tick();
    check("wrap_drop_stop", dump_stop, 1);

    // fe coincident with arm rise and start == frame_cnt.
    cfg_start = exp_cnt; cfg_len = 8'd0;
    arm = 1'b1; vs = 1'b0;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    check("coin_st", st, 1);
    check("coin_no_start", dump_start, 0);
    check("coin_cnt", frame_cnt, exp_cnt);
    vs = 1'b1; tick();
    off_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      frame();
      if (fe_on || fe_start) off_cnt++;
    end
    check("coin_wait_off", off_cnt, 0);
    check("coin_wait_cnt", frame_cnt, 2);
    frame();
    check("coin_late_start", fe_start, 1);

    // Asynchronous reset mid-window: dump_on drops, no stop pulse.
    check("pre_rst_on", dump_on, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_on", dump_on, 0);
    check("async_rst_stop", dump_stop, 0);
    check("async_rst_st", st, 0);
    tick();
    rst_n = 1'b1;
    tick();

    check("start_stop_exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
